fifo32_stream_reader: RTL and testbench

- Consumer-side controller for a 32-entry x 32-bit push/pop FIFO. Drains a commanded number of words, splits each word into two 16-bit halves (low half first), and delivers them to a PE input port over a valid/ready handshake.
- Sits between the global-buffer-fed FIFO and the PE ifmap/filter scratchpad loaders.
- Pops only when the writer is not pushing in the same cycle, so the writer always wins.

---
 rtl/eyeriss_pkg.sv | 16 +
 rtl/fifo32_stream_reader_if.sv | 22 ++
 rtl/fifo32_stream_reader.sv | 93 +++++++++
 tb/tb_fifo32_stream_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eyeriss_pkg.sv
// Shared Eyeriss definitions: FIFO/PE widths and the stream reader FSM encoding.
package eyeriss_pkg;

  localparam int unsigned FIFO_DATA_W = 32;
  localparam int unsigned PE_HALF_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_CAPT    = 3'd2,
    ST_SEND_LO = 3'd3,
    ST_SEND_HI = 3'd4,
    ST_DONE    = 3'd5
  } rd_state_e;

endpackage

// File: rtl/fifo32_stream_reader_if.sv
// FIFO read port plus PE element handshake seen by the stream reader.
interface fifo32_stream_reader_if;

  logic                                fifo_empty;
  logic                                fifo_push;
  logic                                fifo_pop;
  logic [eyeriss_pkg::FIFO_DATA_W-1:0] fifo_dout;
  logic                                out_valid;
  logic [eyeriss_pkg::PE_HALF_W-1:0]   out_data;
  logic                                out_ready;

  modport master (
    input  fifo_empty, fifo_push, fifo_dout, out_ready,
    output fifo_pop, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_push, fifo_dout, out_ready,
    input  fifo_pop, out_valid, out_data
  );

endinterface

// File: rtl/fifo32_stream_reader.sv
// Drains a commanded number of 32-bit FIFO words and streams them out as
// 16-bit halves (low half first); yields the FIFO to the writer on conflict.
module fifo32_stream_reader
  import eyeriss_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      words_left,
  fifo32_stream_reader_if.master bus
);

  localparam int unsigned DATA_W = FIFO_DATA_W;
  localparam int unsigned HALF_W = PE_HALF_W;

  rd_state_e         state_q, state_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              pop_c;

  // State, counter and word register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
    end
  end

  // Next state; pop is only raised in REQ and only when the writer is idle.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    word_d       = word_q;
    pop_c        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          words_left_d = len;
          state_d      = (len != '0) ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        pop_c = ~bus.fifo_empty & ~bus.fifo_push;
        if (pop_c) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        word_d  = bus.fifo_dout;
        state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (bus.out_ready) state_d = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        if (bus.out_ready) begin
          if (words_left_q != '0) words_left_d = words_left_q - LEN_W'(1);
          state_d = (words_left_q <= LEN_W'(1)) ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A pop already issued this cycle still completes; its data is dropped.
    if (abort) begin
      state_d      = ST_IDLE;
      words_left_d = '0;
      word_d       = '0;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign words_left = words_left_q;

  assign bus.fifo_pop  = pop_c;
  assign bus.out_valid = (state_q == ST_SEND_LO) || (state_q == ST_SEND_HI);
  assign bus.out_data  = (state_q == ST_SEND_LO) ? word_q[HALF_W-1:0] :
                         (state_q == ST_SEND_HI) ? word_q[DATA_W-1:HALF_W] :
                                                   HALF_W'(0);

endmodule

// File: tb/tb_fifo32_stream_reader.sv
// Directed bench for fifo32_stream_reader with a behavioural FIFO model.
module tb_fifo32_stream_reader;

  logic       clk = 1'b0;
  logic       rstn, start, abort;
  logic [7:0] len;
  logic       busy, done;
  logic [7:0] words_left;

  fifo32_stream_reader_if bus_if ();

  fifo32_stream_reader #(.LEN_W(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .words_left (words_left),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after an accepted pop.
  logic [31:0] fq[$];
  logic [31:0] push_data;
  always @(posedge clk) begin
    if (bus_if.fifo_push) fq.push_back(push_data);
    if (bus_if.fifo_pop && fq.size() > 0) bus_if.fifo_dout <= fq.pop_front();
    bus_if.fifo_empty <= (fq.size() == 0);
  end

  int          pop_cnt  = 0;
  int          done_cnt = 0;
  logic [15:0] got[$];
  always @(posedge clk) begin
    if (bus_if.fifo_pop) pop_cnt <= pop_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (bus_if.out_valid && bus_if.out_ready) got.push_back(bus_if.out_data);
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    push_data        = w;
    bus_if.fifo_push = 1'b1;
    step();
    bus_if.fifo_push = 1'b0;
  endtask

  task automatic go(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(done), 1);
  endtask

  int p0, d0, g0;
  logic [31:0] t4w [3];

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; len = '0;
    bus_if.fifo_push = 1'b0; bus_if.out_ready = 1'b1; push_data = '0;
    t4w[0] = 32'h2222_1111; t4w[1] = 32'h4444_3333; t4w[2] = 32'h6666_5555;
    step(); step();

    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_pop",   32'(bus_if.fifo_pop), 0);
    chk("rst_valid", 32'(bus_if.out_valid), 0);
    chk("rst_data",  32'(bus_if.out_data), 0);
    chk("rst_wl",    32'(words_left), 0);
    rstn = 1'b1;
    step();

    // Two words, ready high: cycle-exact trace from the start strobe.
    push_word(32'h0002_0001);
    push_word(32'h0004_0003);
    p0 = pop_cnt; d0 = done_cnt; g0 = got.size();
    go(8'd2);
    chk("t1_c1_pop",  32'(bus_if.fifo_pop), 1);
    chk("t1_c1_busy", 32'(busy), 1);
    chk("t1_c1_wl",   32'(words_left), 2);
    step();
    chk("t1_c2_pop",   32'(bus_if.fifo_pop), 0);
    chk("t1_c2_valid", 32'(bus_if.out_valid), 0);
    step();
    chk("t1_c3_valid", 32'(bus_if.out_valid), 1);
    chk("t1_c3_data",  32'(bus_if.out_data), 32'h0001);
    step();
    chk("t1_c4_data", 32'(bus_if.out_data), 32'h0002);
    chk("t1_c4_wl",   32'(words_left), 2);
    step();
    chk("t1_c5_wl",    32'(words_left), 1);
    chk("t1_c5_valid", 32'(bus_if.out_valid), 0);
    chk("t1_c5_pop",   32'(bus_if.fifo_pop), 1);
    step(); step();
    chk("t1_c7_data", 32'(bus_if.out_data), 32'h0003);
    step();
    chk("t1_c8_data", 32'(bus_if.out_data), 32'h0004);
    step();
    // done follows the last accepted half
    chk("t1_c9_done", 32'(done), 1);
    chk("t1_c9_wl",   32'(words_left), 0);
    step();
    chk("t1_c10_done", 32'(done), 0);
    chk("t1_c10_busy", 32'(busy), 0);
    chk("t1_pops",  pop_cnt - p0, 2);
    chk("t1_dones", done_cnt - d0, 1);
    chk("t1_nelem", got.size() - g0, 4);
    chk("t1_e2", 32'(got[g0+2]), 32'h0003);

    // Writer pushes for 3 cycles while reader sits in REQ: writer wins.
    push_word(32'hBEEF_CAFE);
    p0 = pop_cnt;
    go(8'd1);
    push_data = 32'h0B0B_0A0A; bus_if.fifo_push = 1'b1;
    #1;
    chk("t2_blk1", 32'(bus_if.fifo_pop), 0);
    step();
    push_data = 32'h0D0D_0C0C;
    chk("t2_blk2", 32'(bus_if.fifo_pop), 0);
    step();
    push_data = 32'h0F0F_0E0E;
    chk("t2_blk3", 32'(bus_if.fifo_pop), 0);
    step();
    bus_if.fifo_push = 1'b0;
    #1;
    chk("t2_pop", 32'(bus_if.fifo_pop), 1);
    step(); step();
    chk("t2_lo", 32'(bus_if.out_data), 32'hCAFE);
    step();
    chk("t2_hi", 32'(bus_if.out_data), 32'hBEEF);
    step();
    chk("t2_done", 32'(done), 1);
    chk("t2_pops", pop_cnt - p0, 1);
    step();

    // Consumer stalls for 5 cycles in SEND_LO.
    p0 = pop_cnt;
    bus_if.out_ready = 1'b0;
    go(8'd1);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 32'(bus_if.out_valid), 1);
      chk("t3_hold_data",  32'(bus_if.out_data), 32'h0A0A);
      chk("t3_hold_pop",   32'(bus_if.fifo_pop), 0);
    end
    step();
    bus_if.out_ready = 1'b1;
    step();
    chk("t3_hi", 32'(bus_if.out_data), 32'h0B0B);
    step();
    chk("t3_done", 32'(done), 1);
    chk("t3_pops", pop_cnt - p0, 1);
    step();

    // start while busy is ignored and len is not resampled.
    p0 = pop_cnt; g0 = got.size();
    go(8'd2);
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    chk("t3b_wl", 32'(words_left), 2);
    wait_done("t3b_done_seen");
    chk("t3b_wl_end", 32'(words_left), 0);
    chk("t3b_pops", pop_cnt - p0, 2);
    chk("t3b_e0", 32'(got[g0]),   32'h0C0C);
    chk("t3b_e3", 32'(got[g0+3]), 32'h0F0F);
    step(); step();
    chk("t3b_idle", 32'(busy), 0);

    // Empty FIFO, len=3, one push every 6 cycles.
    g0 = got.size();
    go(8'd3);
    chk("t4_wait_pop", 32'(bus_if.fifo_pop), 0);
    chk("t4_wl0",      32'(words_left), 3);
    for (int k = 0; k < 3; k++) begin
      push_data = t4w[k]; bus_if.fifo_push = 1'b1;
      #1;
      chk("t4_push_nopop", 32'(bus_if.fifo_pop), 0);
      step();
      bus_if.fifo_push = 1'b0;
      #1;
      chk("t4_pop", 32'(bus_if.fifo_pop), 1);
      step(); step(); step(); step();
      chk("t4_wl", 32'(words_left), 32'(2 - k));
      if (k < 2) begin
        chk("t4_idle_pop", 32'(bus_if.fifo_pop), 0);
        step();
      end else begin
        chk("t4_done", 32'(done), 1);
      end
    end
    chk("t4_nelem", got.size() - g0, 6);
    chk("t4_e1", 32'(got[g0+1]), 32'h2222);
    chk("t4_e4", 32'(got[g0+4]), 32'h5555);
    step();

    // Abort in SEND_HI with a handshake pending.
    push_word(32'h1234_5678);
    push_word(32'h9ABC_DEF0);
    d0 = done_cnt;
    go(8'd4);
    step(); step();
    chk("t5_lo", 32'(bus_if.out_data), 32'h5678);
    step();
    chk("t5_hi", 32'(bus_if.out_data), 32'h1234);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_busy",  32'(busy), 0);
    chk("t5_wl",    32'(words_left), 0);
    chk("t5_done",  32'(done), 0);
    chk("t5_valid", 32'(bus_if.out_valid), 0);
    step(); step();
    chk("t5_nodone", done_cnt - d0, 0);
    go(8'd1);
    chk("t5_restart_pop", 32'(bus_if.fifo_pop), 1);
    wait_done("t5_restart_done");
    chk("t5_r_lo", 32'(got[got.size()-2]), 32'hDEF0);
    chk("t5_r_hi", 32'(got[got.size()-1]), 32'h9ABC);
    step();

    // len=0 completes immediately without popping.
    p0 = pop_cnt;
    go(8'd0);
    chk("t6_done", 32'(done), 1);
    chk("t6_pop",  32'(bus_if.fifo_pop), 0);
    step();
    chk("t6_done_clr", 32'(done), 0);
    chk("t6_busy",     32'(busy), 0);
    chk("t6_pops",     pop_cnt - p0, 0);

    // Async reset mid-REQ while a pop is being requested.
    push_word(32'hAAAA_5555);
    go(8'd2);
    chk("t7_pop_pre", 32'(bus_if.fifo_pop), 1);
    #1;
    rstn = 1'b0;
    #1;
    chk("t7_busy",  32'(busy), 0);
    chk("t7_done",  32'(done), 0);
    chk("t7_pop",   32'(bus_if.fifo_pop), 0);
    chk("t7_valid", 32'(bus_if.out_valid), 0);
    chk("t7_data",  32'(bus_if.out_data), 0);
    chk("t7_wl",    32'(words_left), 0);
    step();
    rstn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
